// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : Two-producer writeback FIFO feeding the single register file
//               write port, with read-after-write hazard probes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] addr_w,
    output logic [DATA_W-1:0] data_w,
    output logic              write_en,
    input  logic [ADDR_W-1:0] chk_addr_a,
    input  logic [ADDR_W-1:0] chk_addr_b,
    output logic              pend_a,
    output logic              pend_b,
    output logic              idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_free;
    logic              w_a_push;
    logic              w_b_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_b_slot;
    logic [PTR_W-1:0]  w_off [DEPTH];
    logic [DEPTH-1:0]  w_occ;

    // Free space ignores a same-cycle pop so the queue can never overfill.
    assign w_free   = CNT_W'(DEPTH) - r_count;
    assign a_ready  = (w_free != '0);
    assign b_ready  = (w_free >= CNT_W'(2)) | ((w_free != '0) & ~a_valid);

    // R0 writes complete their handshake but never occupy a slot.
    assign w_a_push = a_valid & a_ready & (a_addr != '0);
    assign w_b_push = b_valid & b_ready & (b_addr != '0);
    assign w_pop    = (r_count != '0);
    assign w_b_slot = r_tail + PTR_W'(w_a_push);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            write_en <= 1'b0;
            addr_w   <= '0;
            data_w   <= '0;
        end else begin
            if (w_pop) begin
                addr_w   <= r_addr_mem[r_head];
                data_w   <= r_data_mem[r_head];
                write_en <= 1'b1;
                r_head   <= r_head + PTR_W'(1);
            end else begin
                write_en <= 1'b0;
            end
            r_tail  <= r_tail + PTR_W'(w_a_push) + PTR_W'(w_b_push);
            r_count <= r_count + CNT_W'(w_a_push) + CNT_W'(w_b_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_a_push) begin
            r_addr_mem[r_tail] <= a_addr;
            r_data_mem[r_tail] <= a_data;
        end
        if (w_b_push) begin
            r_addr_mem[w_b_slot] <= b_addr;
            r_data_mem[w_b_slot] <= b_data;
        end
    end

    // A slot is occupied when its distance from head is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
        assign w_off[gi] = PTR_W'(gi) - r_head;
        assign w_occ[gi] = (CNT_W'(w_off[gi]) < r_count);
    end

    always_comb begin
        pend_a = write_en & (addr_w == chk_addr_a);
        pend_b = write_en & (addr_w == chk_addr_b);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_occ[i] && (r_addr_mem[i] == chk_addr_a)) pend_a = 1'b1;
            if (w_occ[i] && (r_addr_mem[i] == chk_addr_b)) pend_b = 1'b1;
        end
        if (chk_addr_a == '0) pend_a = 1'b0;
        if (chk_addr_b == '0) pend_b = 1'b0;
    end

    assign idle = (r_count == '0) & ~write_en;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_queue
// Description : Self-checking bench for regfile_wb_queue against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [3:0]  a_addr, b_addr, addr_w, chk_addr_a, chk_addr_b;
    logic [31:0] a_data, b_data, data_w;
    logic        write_en, pend_a, pend_b, idle;

    regfile_wb_queue #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .addr_w(addr_w), .data_w(data_w), .write_en(write_en),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
        .pend_a(pend_a), .pend_b(pend_b), .idle(idle)
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    logic        m_we;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic        e_ar, e_br, e_pa, e_pb;
    logic        o_ar, o_br, o_pa, o_pb;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic m_pend(logic [3:0] c);
        if (c == 4'd0) return 1'b0;
        if (m_we && m_addr == c) return 1'b1;
        foreach (q[i]) if (q[i].a == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_idle();
        return (q.size() == 0) && !m_we;
    endfunction

    // Samples pre-edge ready/pend, advances one clock, updates the model.
    task automatic cycle();
        int   free;
        ent_t e;
        #1;
        free = DEPTH - q.size();
        e_ar = (free >= 1);
        e_br = (free >= 2) || (free >= 1 && !a_valid);
        e_pa = m_pend(chk_addr_a);
        e_pb = m_pend(chk_addr_b);
        o_ar = a_ready; o_br = b_ready; o_pa = pend_a; o_pb = pend_b;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                m_we = 1'b1; m_addr = e.a; m_data = e.d;
            end else begin
                m_we = 1'b0;
            end
            if (a_valid && e_ar && a_addr != 4'd0) q.push_back(ent_t'({a_addr, a_data}));
            if (b_valid && e_br && b_addr != 4'd0) q.push_back(ent_t'({b_addr, b_data}));
        end
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
        chk_addr_a = 0; chk_addr_b = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; cycle(); cycle(); rst = 0; #1;
        n_checks++;
        if ({write_en, addr_w, data_w} !== 37'd0) begin
            n_fail++; $display("FAIL reset_out got we=%b a=%h d=%h exp 0/0/0", write_en, addr_w, data_w);
        end
        n_checks++;
        if ({a_ready, b_ready, pend_a, pend_b, idle} !== 5'b11001) begin
            n_fail++; $display("FAIL reset_flags got %b exp 11001", {a_ready, b_ready, pend_a, pend_b, idle});
        end
    endtask

    task automatic test_single();
        logic [3:0] we_seen;
        rst = 1; cycle(); rst = 0;
        a_valid = 1; a_addr = 3; a_data = 32'hDEADBEEF; chk_addr_a = 3;
        we_seen = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            a_valid = 0;
            we_seen[i] = write_en;
            if (i == 1) begin
                n_checks++;
                if ({addr_w, data_w} !== {4'd3, 32'hDEADBEEF}) begin
                    n_fail++; $display("FAIL single_data got a=%h d=%h exp 3/deadbeef", addr_w, data_w);
                end
            end
            n_checks++;
            if (pend_a !== (i <= 1)) begin
                n_fail++; $display("FAIL single_pend cyc%0d got %b exp %b", i, pend_a, (i <= 1));
            end
        end
        n_checks++;
        if ({we_seen, idle} !== 5'b00101) begin
            n_fail++; $display("FAIL single_we got we=%b idle=%b exp we=0010 idle=1", we_seen, idle);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] seq [2];
        a_valid = 1; a_addr = 1; a_data = 32'h11;
        b_valid = 1; b_addr = 2; b_data = 32'h22;
        cycle();
        a_valid = 0; b_valid = 0;
        n_checks++;
        if ({o_ar, o_br} !== 2'b11) begin
            n_fail++; $display("FAIL simul_ready got %b exp 11", {o_ar, o_br});
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            seq[i] = write_en ? addr_w : 4'hF;
        end
        n_checks++;
        if ({seq[0], seq[1]} !== 8'h12) begin
            n_fail++; $display("FAIL simul_order got %h%h exp 12", seq[0], seq[1]);
        end
        cycle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 9; i++) begin
            a_valid = (i < 3); b_valid = (i < 3);
            a_addr = 4'(1 + i); b_addr = 4'(8 + i);
            a_data = $urandom; b_data = $urandom;
            chk_addr_a = 4'($urandom_range(0, 15)); chk_addr_b = 4'($urandom_range(0, 15));
            cycle();
            n_checks++;
            if ({write_en, addr_w, data_w} !== {m_we, m_addr, m_data}) begin
                n_fail++; $display("FAIL fill_wb got %b/%h/%h exp %b/%h/%h", write_en, addr_w, data_w, m_we, m_addr, m_data);
            end
            n_checks++;
            if ({o_ar, o_br, o_pa, o_pb, idle} !== {e_ar, e_br, e_pa, e_pb, m_idle()}) begin
                n_fail++; $display("FAIL fill_flags got %b exp %b", {o_ar, o_br, o_pa, o_pb, idle}, {e_ar, e_br, e_pa, e_pb, m_idle()});
            end
        end
        idle_inputs();
    endtask

    task automatic test_r0();
        a_valid = 1; a_addr = 0; a_data = 32'hFFFFFFFF; chk_addr_a = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({o_ar, o_pa, write_en, idle} !== 4'b1001) begin
                n_fail++; $display("FAIL r0 got rdy/pend/we/idle=%b exp 1001", {o_ar, o_pa, write_en, idle});
            end
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_same_reg();
        logic [31:0] got [$];
        chk_addr_b = 5;
        for (int i = 0; i < 7; i++) begin
            a_valid = (i < 3); a_addr = 5; a_data = 32'(i + 1);
            cycle();
            if (write_en) got.push_back(data_w);
            n_checks++;
            if (o_pb !== e_pb || pend_b !== m_pend(4'd5)) begin
                n_fail++; $display("FAIL same_pend cyc%0d got %b/%b exp %b/%b", i, o_pb, pend_b, e_pb, m_pend(4'd5));
            end
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
            n_fail++; $display("FAIL same_order got %0d pulses first=%h exp 3 pulses 1,2,3", got.size(), (got.size() > 0) ? got[0] : 32'hX);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            a_valid = 1; b_valid = 1;
            a_addr = 4'(6 + i); b_addr = 4'(10 + i); a_data = $urandom; b_data = $urandom;
            cycle();
        end
        idle_inputs();
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({write_en, idle} !== 2'b01) begin
                n_fail++; $display("FAIL rstmid cyc%0d got we/idle=%b exp 01", i, {write_en, idle});
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            a_valid = $urandom_range(0, 1); b_valid = $urandom_range(0, 1);
            a_addr = 4'($urandom_range(0, 15)); b_addr = 4'($urandom_range(0, 15));
            a_data = $urandom; b_data = $urandom;
            chk_addr_a = 4'($urandom_range(0, 15)); chk_addr_b = 4'($urandom_range(0, 15));
            cycle();
            n_checks++;
            if ({write_en, addr_w, data_w} !== {m_we, m_addr, m_data}) begin
                n_fail++; $display("FAIL rand_wb cyc%0d got %b/%h/%h exp %b/%h/%h", i, write_en, addr_w, data_w, m_we, m_addr, m_data);
            end
            n_checks++;
            if ({o_ar, o_br, o_pa, o_pb, idle} !== {e_ar, e_br, e_pa, e_pb, m_idle()}) begin
                n_fail++; $display("FAIL rand_flags cyc%0d got %b exp %b", i, {o_ar, o_br, o_pa, o_pb, idle}, {e_ar, e_br, e_pa, e_pb, m_idle()});
            end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        m_we = 0; m_addr = 0; m_data = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_fill();
        test_r0();
        test_same_reg();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
